// File: rtl/tempsense_pkg.sv
// Shared types and default constants for the temperature-sense result capture block.
package tempsense_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    WAIT_LOW = 2'd2
  } ts_state_e;

  localparam int TS_DW          = 10;
  localparam int TS_TIMEOUT_CYC = 4096;

endpackage

// File: rtl/tempsense_done_sync.sv
// Brings the asynchronous ADC DONE level into HF_CLK and emits a one-cycle rising-edge pulse.
module tempsense_done_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic HF_CLK,
  input  logic NRST_sync,
  input  logic DONE,
  output logic done_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   done_prev;

  always_ff @(posedge HF_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      sync_q    <= '0;
      done_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], DONE};
      done_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  // done_prev resets low, so a DONE held high across reset release still yields one pulse
  assign done_rise = sync_q[SYNC_STAGES-1] & ~done_prev;

endmodule

// File: rtl/tempsense_result_capture.sv
// Captures the ADC result on the first synchronised DONE edge of a temp_run window.
// Optional alarm comparator enabled by defining TEMPSENSE_ALARM_EN.
module tempsense_result_capture
  import tempsense_pkg::*;
#(
  parameter int DW          = TS_DW,
  parameter int TIMEOUT_CYC = TS_TIMEOUT_CYC,
  parameter int SYNC_STAGES = 2
) (
  input  logic          HF_CLK,
  input  logic          NRST_sync,
  input  logic          temp_run,
  input  logic          DONE,
  input  logic [DW-1:0] ADC_DATA,
  input  logic          RD_ACK,
  input  logic [DW-1:0] THRESH,
  output logic [DW-1:0] TEMP_DATA,
  output logic          TEMP_VALID,
  output logic          TEMP_OVR,
  output logic          TEMP_TIMEOUT,
  output logic          TEMP_ALARM
);

  localparam int            TW     = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  ts_state_e     state_q, state_n;
  logic [TW-1:0] timer_q, timer_n;
  logic          done_rise;
  logic          capture, to_set, to_clr;

  tempsense_done_sync #(.SYNC_STAGES(SYNC_STAGES)) u_done_sync (
    .HF_CLK    (HF_CLK),
    .NRST_sync (NRST_sync),
    .DONE      (DONE),
    .done_rise (done_rise)
  );

  always_ff @(posedge HF_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_n;
      timer_q <= timer_n;
    end
  end

  always_comb begin
    state_n = state_q;
    timer_n = timer_q;
    capture = 1'b0;
    to_set  = 1'b0;
    to_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        timer_n = '0;
        if (temp_run) begin
          state_n = ARMED;
          to_clr  = 1'b1;
        end
      end
      ARMED: begin
        // saturate rather than wrap; the terminal count leaves ARMED anyway
        if (timer_q != T_LAST) timer_n = timer_q + 1'b1;
        if (done_rise) begin
          capture = 1'b1;
          state_n = WAIT_LOW;
        end else if (timer_q == T_LAST) begin
          to_set  = 1'b1;
          state_n = WAIT_LOW;
        end else if (!temp_run) begin
          state_n = IDLE;
        end
      end
      WAIT_LOW: begin
        timer_n = '0;
        if (!temp_run) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  // A capture coincident with RD_ACK wins: the new word is unread, so no overrun
  always_ff @(posedge HF_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      TEMP_DATA    <= '0;
      TEMP_VALID   <= 1'b0;
      TEMP_OVR     <= 1'b0;
      TEMP_TIMEOUT <= 1'b0;
    end else begin
      if (to_clr)      TEMP_TIMEOUT <= 1'b0;
      else if (to_set) TEMP_TIMEOUT <= 1'b1;
      if (capture) begin
        TEMP_DATA  <= ADC_DATA;
        TEMP_VALID <= 1'b1;
        TEMP_OVR   <= TEMP_VALID & ~RD_ACK;
      end else if (RD_ACK) begin
        TEMP_VALID <= 1'b0;
        TEMP_OVR   <= 1'b0;
      end
    end
  end

`ifdef TEMPSENSE_ALARM_EN
  // Sticky until read: a later low sample without RD_ACK keeps the alarm
  always_ff @(posedge HF_CLK or negedge NRST_sync) begin
    if (!NRST_sync)   TEMP_ALARM <= 1'b0;
    else if (capture) TEMP_ALARM <= (ADC_DATA >= THRESH) | (TEMP_ALARM & ~RD_ACK);
    else if (RD_ACK)  TEMP_ALARM <= 1'b0;
  end
`else
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
  assign TEMP_ALARM    = 1'b0;
`endif

endmodule
